debounce_multi: RTL
===================

Name: debounce_multi

Overview:
Parametrised successor to the fixed 5-button/8-switch debouncer. It debounces NUM_CH asynchronous mechanical inputs (pushbuttons, slide switches, rotary contacts) with a configurable sample period and stability depth. It adds per-channel rise/fall pulses and an optional auto-repeat "press" pulse for held buttons. It sits between board I/O pins and the application logic or the I/O peripheral registers.

Parameters:
NUM_CH, 8, number of independent input channels (>=1)
SAMPLE_PERIOD, 4_000_000, clk cycles between samples (>=1); 40 ms at 100 MHz
STABLE_CNT, 4, consecutive equal samples required to change the output (>=2)
REPEAT_EN, 0, 1 enables auto-repeat on press; 0 makes press identical to rise
REPEAT_DELAY, 25, sample ticks from rise to the first repeat pulse (>=1)
REPEAT_RATE, 5, sample ticks between subsequent repeat pulses (>=1)

Ports:
clk  input  1  system clock; all logic on posedge
reset_n  input  1  synchronous, active-low reset
din  input  NUM_CH  raw asynchronous inputs
db_out  output  NUM_CH  debounced level per channel
rise  output  NUM_CH  one-clk pulse when db_out goes 0->1
fall  output  NUM_CH  one-clk pulse when db_out goes 1->0
press  output  NUM_CH  one-clk pulse on rise, plus auto-repeat pulses when enabled
tick  output  1  one-clk sample strobe, for observation and test

Behaviour:
- Interface (decided): one clock, clk. Reset reset_n is synchronous and active-low; it is sampled only on posedge clk.
- Reset (reset_n=0 at a posedge): all registers clear to 0. This covers the synchronizers, prescaler, shift registers, db_out, rise, fall, press, tick, repeat counters and phase bits.
- Synchronizer: 2-FF synchronizer per channel on din; s = second stage output.
- Prescaler:
  - Counter width $clog2(SAMPLE_PERIOD+1); counts 0..SAMPLE_PERIOD-1.
  - tick is registered and high for exactly one clk when the counter equals SAMPLE_PERIOD-1; the counter then wraps to 0.
  - SAMPLE_PERIOD=1 gives tick high every cycle after reset.
- Per-channel filter:
  - STABLE_CNT-bit shift register sh. On tick: sh_next = {sh[STABLE_CNT-2:0], s}.
  - On that same edge: db_out <= 1 if sh_next is all ones; db_out <= 0 if all zeros; otherwise db_out holds.
  - No tick: sh and db_out hold.
- Edge pulses:
  - rise <= db_next & ~db_out; fall <= ~db_next & db_out. Registered on the same edge db_out updates, so each pulse is exactly 1 clk wide.
  - rise and fall are never high together on a channel.
- Latency: an input change that is clean thereafter reaches db_out within 2 + STABLE_CNT*SAMPLE_PERIOD clk, and no earlier than 2 + (STABLE_CNT-1)*SAMPLE_PERIOD + 1 clk.
- Input held high through reset: after reset releases, db_out goes 1 after STABLE_CNT ticks and produces one rise pulse. This is intended.
- Auto-repeat (REPEAT_EN=1), per channel:
  - State: repeat counter rc (width $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)) and phase bit ph.
  - On rise: press=1, rc<=0, ph<=0.
  - On a tick while db_out=1 and no fall: rc increments. When rc+1 reaches the target (ph=0: REPEAT_DELAY; ph=1: REPEAT_RATE), press pulses, rc<=0, ph<=1.
  - On fall, or while db_out=0: rc<=0, ph<=0, no press.
  - Simultaneous events: a tick that causes fall produces no press, so fall wins.
  - The rise tick itself does not increment rc.
- REPEAT_EN=0: press == rise every cycle; the repeat logic may be removed.
- Reset mid-operation: all state clears on that edge. No rise/fall/press pulse is generated by reset itself.
- Channels are fully independent. A tick serves all channels in the same cycle.

Test Plan:
1. NUM_CH=2, SAMPLE_PERIOD=4, STABLE_CNT=3, REPEAT_EN=0. Hold din=2'b00 through reset, then set din[0]=1 clean -> db_out[0]=1 within 14 clk. Exactly one rise[0] pulse, press[0] coincident, no fall, db_out[1] stays 0.
2. Same config, din[0] toggling every 4 clk for 100 clk -> db_out[0], rise and fall never change from 0. Then hold din[0]=1 -> rise after <=14 clk. Release to 0 -> one fall pulse within 14 clk.
3. SAMPLE_PERIOD=4, check tick -> period exactly 4 clk, width 1 clk, first tick 4 clk after reset release. SAMPLE_PERIOD=1 -> tick high every cycle.
4. REPEAT_EN=1, REPEAT_DELAY=3, REPEAT_RATE=2, din[1] held high 60 clk -> press[1] at rise, again 12 clk later, then every 8 clk. Release -> fall pulse, no press on the fall tick, rc cleared. Re-press restarts the 12-clk delay.
5. din=2'b11 held through reset release -> both db_out go 1 on the same edge after 3 ticks, with simultaneous rise pulses.
6. Assert reset_n=0 for 1 clk while db_out[0]=1 mid-repeat -> next cycle all outputs 0, no pulses. With din still 1, rise reoccurs after 3 ticks.

Source files
------------

// File: rtl/debounce_multi.sv
// Multi-channel debouncer: 2-FF sync, shared sample prescaler, per-channel shift filter, rise/fall/press pulses.
// db_out lags a clean input change by 2+(STABLE_CNT-1)*SAMPLE_PERIOD+1 .. 2+STABLE_CNT*SAMPLE_PERIOD clk; no backpressure.
module debounce_multi #(
   parameter int NUM_CH        = 8,
   parameter int SAMPLE_PERIOD = 4_000_000,
   parameter int STABLE_CNT    = 4,
   parameter int REPEAT_EN     = 0,
   parameter int REPEAT_DELAY  = 25,
   parameter int REPEAT_RATE   = 5
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [NUM_CH-1:0] din,
   output logic [NUM_CH-1:0] db_out,
   output logic [NUM_CH-1:0] rise,
   output logic [NUM_CH-1:0] fall,
   output logic [NUM_CH-1:0] press,
   output logic              tick
);

   localparam int PW   = $clog2(SAMPLE_PERIOD + 1);
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RCW  = $clog2(RMAX + 1);

   logic [NUM_CH-1:0] r_sync1, r_sync2;
   logic [PW-1:0]     r_pcnt;
   logic              r_tick;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
      end else begin
         r_sync1 <= din;
         r_sync2 <= r_sync1;
      end
   end

   // One tick serves every channel; it is registered so the filter sees it one edge later.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_pcnt <= '0;
         r_tick <= 1'b0;
      end else if (r_pcnt == PW'(SAMPLE_PERIOD - 1)) begin
         r_pcnt <= '0;
         r_tick <= 1'b1;
      end else begin
         r_pcnt <= r_pcnt + 1'b1;
         r_tick <= 1'b0;
      end
   end

   assign tick = r_tick;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      logic [STABLE_CNT-1:0] r_sh, w_sh_next;
      logic                  r_db, r_rise, r_fall, r_press;
      logic                  w_db_next, w_rise_ev, w_fall_ev, w_rep_ev;

      always_comb begin
         w_sh_next = r_sh;
         w_db_next = r_db;
         if (r_tick) begin
            w_sh_next = {r_sh[STABLE_CNT-2:0], r_sync2[i]};
            if (&w_sh_next) begin
               w_db_next = 1'b1;
            end else if (~|w_sh_next) begin
               w_db_next = 1'b0;
            end
         end
      end

      assign w_rise_ev = w_db_next & ~r_db;
      assign w_fall_ev = ~w_db_next & r_db;

      if (REPEAT_EN != 0) begin : g_rep
         logic [RCW-1:0] r_rc, w_rc_inc, w_target;
         logic           r_ph;

         assign w_rc_inc = r_rc + 1'b1;
         assign w_target = r_ph ? RCW'(REPEAT_RATE) : RCW'(REPEAT_DELAY);
         // A tick that drops db_out must not also repeat: fall takes priority.
         assign w_rep_ev = r_tick & r_db & ~w_fall_ev & (w_rc_inc == w_target);

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               r_rc <= '0;
               r_ph <= 1'b0;
            end else if (!r_db || w_fall_ev) begin
               r_rc <= '0;
               r_ph <= 1'b0;
            end else if (r_tick) begin
               if (w_rc_inc == w_target) begin
                  r_rc <= '0;
                  r_ph <= 1'b1;
               end else begin
                  r_rc <= w_rc_inc;
               end
            end
         end
      end else begin : g_norep
         assign w_rep_ev = 1'b0;
      end

      always_ff @(posedge clk) begin
         if (!reset_n) begin
            r_sh    <= '0;
            r_db    <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_press <= 1'b0;
         end else begin
            r_sh    <= w_sh_next;
            r_db    <= w_db_next;
            r_rise  <= w_rise_ev;
            r_fall  <= w_fall_ev;
            r_press <= w_rise_ev | w_rep_ev;
         end
      end

      assign db_out[i] = r_db;
      assign rise[i]   = r_rise;
      assign fall[i]   = r_fall;
      assign press[i]  = r_press;
   end

endmodule
